lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 lsu_op_i  in  lsu_op_t  MEM-stage op; one of LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD.
REQ-004 addr_i  in  64  byte address (EX/MEM ALU result).
REQ-005 store_data_i  in  64  store operand, right-aligned.
REQ-006 mem_req_o / mem_we_o  out  1 / 1  request valid; write enable.
REQ-007 mem_addr_o  out  64  doubleword address: addr with bits [2:0] forced to 0.
REQ-008 mem_be_o / mem_wdata_o  out  8 / 64  byte lanes; lane-shifted write data.
REQ-009 mem_gnt_i / mem_rvalid_i  in  1 / 1  request accepted; response/ack valid.
REQ-010 mem_rdata_i  in  64  read doubleword, valid with mem_rvalid_i.
REQ-011 stall_o  out  1  freeze IF..EX/MEM registers this cycle.
REQ-012 load_data_o / load_valid_o  out  64 / 1  extended load result; 1-cycle completion strobe.
REQ-013 misaligned_o  out  1  combinational misaligned-access flag.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, DONE.
REQ-015 IDLE: op != NONE and aligned -> latch op/addr/data, go REQ; otherwise stay IDLE.
REQ-016 Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0; B is always aligned.
REQ-017 Misaligned op in IDLE: misaligned_o=1 same cycle, no request, stall_o=0, state stays IDLE.
REQ-018 REQ: mem_req_o=1, with addr/we/be/wdata from latched values held stable until mem_gnt_i=1; then go WAIT.
REQ-019 WAIT: mem_req_o=0; on mem_rvalid_i=1 go DONE, and register the extended load_data_o (loads only).
REQ-020 mem_rvalid_i in the same cycle as mem_gnt_i (REQ state) is ignored; mem_rvalid_i in IDLE/DONE is ignored.
REQ-021 DONE: load_valid_o=1 for loads (0 for stores), stall_o=0; go IDLE next cycle.
REQ-022 stall_o=1 when (IDLE and aligned op != NONE) or state in {REQ, WAIT}; 0 otherwise.
REQ-023 Minimum latency with gnt in the first REQ cycle and rvalid the next cycle: stall for 3 cycles; DONE in the 4th cycle.
REQ-024 Stores also wait for mem_rvalid_i as the write ack.
REQ-025 Byte enables, off=addr[2:0]: B 0x01<<off, H 0x03<<off, W 0x0F<<off, D 0xFF.
REQ-026 mem_wdata_o = store_data << (8*off); mem_we_o=1 only for SB/SH/SW/SD.
REQ-027 Load data: r = rdata >> (8*off); LB/LH/LW sign-extend r[7:0]/[15:0]/[31:0]; LBU/LHU/LWU zero-extend; LD uses r unchanged.
REQ-028 load_data_o holds its value until the next load completes.
REQ-029 In DONE, a new op on lsu_op_i is not sampled; the op is evaluated next cycle in IDLE.

Reset
REQ-030 Async assert -> IDLE; mem_req_o, mem_we_o, stall_o, load_valid_o, misaligned_o = 0.
REQ-031 Async assert -> mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, load_data_o=0.
REQ-032 Reset mid-transaction (REQ/WAIT) abandons it; a late mem_rvalid_i after release is ignored in IDLE.

Verification
REQ-033 LD addr 0x1000, gnt at cycle 1, rvalid at cycle 2 with rdata 0x1122334455667788 -> stall cycles 0-2; cycle 3 load_valid_o=1, load_data_o=0x1122334455667788.
REQ-034 LB addr 0x1003, rdata 0x00000000_80000000 -> mem_be_o=0x08, load_data_o=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
REQ-035 SH addr 0x2006, data 0xABCD -> mem_be_o=0xC0, mem_wdata_o=0xABCD000000000000, mem_we_o=1, load_valid_o=0 in DONE.
REQ-036 LW addr 0x3002 -> misaligned_o=1, mem_req_o=0, stall_o=0.
REQ-037 gnt withheld for 5 cycles -> mem_req_o and mem_addr_o stable throughout; stall_o=1 until DONE.
REQ-038 rst_n pulsed while in WAIT, then rvalid -> outputs at reset values, no load_valid_o.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller for the MEM stage.
//   Takes one memory op per transaction from the pipeline, checks alignment,
//   issues a single doubleword request (byte lanes + lane-shifted store data),
//   waits for the grant and then for the response/ack, and returns the
//   sign/zero-extended load result with a one-cycle valid strobe.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   lsu_op_i              MEM-stage op (lsu_op_t)
//   addr_i, store_data_i  byte address, right-aligned store operand
//   mem_req_o, mem_we_o   request valid, write enable (registered)
//   mem_addr_o            doubleword address (registered)
//   mem_be_o, mem_wdata_o byte lanes, lane-shifted write data (registered)
//   mem_gnt_i             request accepted
//   mem_rvalid_i          read data / write ack valid
//   mem_rdata_i           read doubleword
//   stall_o               freeze IF..EX/MEM this cycle (combinational)
//   load_data_o           extended load result, held until the next load
//   load_valid_o          one-cycle load completion strobe
//   misaligned_o          misaligned-access flag (combinational)

package lsu_pkg;
  localparam int DATA_W = 64;

  typedef enum logic [3:0] {
    LSU_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  } lsu_op_t;
endpackage

module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  lsu_op_t           lsu_op_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [7:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              misaligned_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_log2(input lsu_op_t op);
    case (op)
      LB, LBU, SB: size_log2 = 2'd0;
      LH, LHU, SH: size_log2 = 2'd1;
      LW, LWU, SW: size_log2 = 2'd2;
      default:     size_log2 = 2'd3;
    endcase
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    is_store = (op == SB) || (op == SH) || (op == SW) || (op == SD);
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    is_load = (op == LB) || (op == LH) || (op == LW) || (op == LD) ||
              (op == LBU) || (op == LHU) || (op == LWU);
  endfunction

  function automatic logic is_aligned(input lsu_op_t op, input logic [2:0] off);
    case (size_log2(op))
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = (off[0] == 1'b0);
      2'd2:    is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

  function automatic logic [7:0] byte_en(input lsu_op_t op, input logic [2:0] off);
    case (size_log2(op))
      2'd0:    byte_en = 8'h01 << off;
      2'd1:    byte_en = 8'h03 << off;
      2'd2:    byte_en = 8'h0F << off;
      default: byte_en = 8'hFF;
    endcase
  endfunction

  // Bring the addressed lane down to bit 0, then extend to the full width.
  function automatic logic [DATA_W-1:0] load_extend(input lsu_op_t op,
                                                    input logic [DATA_W-1:0] rdata,
                                                    input logic [2:0] off);
    logic        [DATA_W-1:0] r;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [31:0]       w;
    r = rdata >> {off, 3'b000};
    b = r[7:0];
    h = r[15:0];
    w = r[31:0];
    case (op)
      LB:      load_extend = 64'(b);
      LH:      load_extend = 64'(h);
      LW:      load_extend = 64'(w);
      LBU:     load_extend = {56'd0, r[7:0]};
      LHU:     load_extend = {48'd0, r[15:0]};
      LWU:     load_extend = {32'd0, r[31:0]};
      default: load_extend = r;
    endcase
  endfunction

  state_t              state_q;
  lsu_op_t             op_q;
  logic [2:0]          off_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic [7:0]          mem_be_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   load_data_q;
  logic                load_valid_q;

  logic [2:0]          off_d;
  logic                op_valid_d;
  logic                aligned_d;
  logic                in_idle_d;
  logic                start_d;
  logic [DATA_W-1:0]   wdata_d;

  assign off_d      = addr_i[2:0];
  assign op_valid_d = (lsu_op_i != LSU_NONE);
  assign aligned_d  = is_aligned(lsu_op_i, off_d);
  assign in_idle_d  = (state_q == S_IDLE);
  assign start_d    = in_idle_d && op_valid_d && aligned_d;
  assign wdata_d    = store_data_i << {off_d, 3'b000};

  // The op is only evaluated in IDLE; while busy the pipeline is frozen and
  // the held op must not raise a flag. Both flags are forced low in reset.
  assign misaligned_o = rst_n && in_idle_d && op_valid_d && !aligned_d;
  assign stall_o      = rst_n && (start_d || (state_q == S_REQ) || (state_q == S_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= LSU_NONE;
      off_q        <= 3'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 8'h00;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      case (state_q)
        // IDLE: capture the op and present the request from the next cycle
        S_IDLE: begin
          if (start_d) begin
            op_q        <= lsu_op_i;
            off_q       <= off_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_store(lsu_op_i);
            mem_addr_q  <= {addr_i[DATA_W-1:3], 3'b000};
            mem_be_q    <= byte_en(lsu_op_i, off_d);
            mem_wdata_q <= wdata_d;
            state_q     <= S_REQ;
          end
        end
        // REQ: hold the request stable until it is granted; an rvalid
        // arriving together with the grant belongs to nothing and is dropped
        S_REQ: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        // WAIT: response for loads, write ack for stores
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= S_DONE;
            if (is_load(op_q)) begin
              load_data_q  <= load_extend(op_q, mem_rdata_i, off_q);
              load_valid_q <= 1'b1;
            end
          end
        end
        // DONE: completion cycle; the next op is looked at back in IDLE
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed transactions with a transaction-level
// expectation model checked every cycle, plus literal pins on key results.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  lsu_op_t     lsu_op_i;
  logic [63:0] addr_i, store_data_i, mem_rdata_i;
  logic        mem_gnt_i, mem_rvalid_i;
  logic        mem_req_o, mem_we_o, stall_o, load_valid_o, misaligned_o;
  logic [63:0] mem_addr_o, mem_wdata_o, load_data_o;
  logic [7:0]  mem_be_o;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .lsu_op_i(lsu_op_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected outputs for the current cycle
  logic        exp_req, exp_we, exp_stall, exp_lv, exp_mis;
  logic [63:0] exp_addr, exp_wdata, exp_ld;
  logic [7:0]  exp_be;

  // snapshot of DUT outputs at the last checked negedge
  logic        snap_req, snap_we, snap_stall, snap_lv, snap_mis;
  logic [63:0] snap_wdata, snap_ld, snap_addr;
  logic [7:0]  snap_be;
  int          stall_cnt;

  // values captured during the last transaction for literal pins
  logic [7:0]  pin_be;
  logic [63:0] pin_wdata, pin_ld;
  logic        pin_we, pin_lv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int m_bytes(input lsu_op_t op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, LWU, SW: return 4;
      default:     return 8;
    endcase
  endfunction

  function automatic bit m_store(input lsu_op_t op);
    return op inside {SB, SH, SW, SD};
  endfunction

  function automatic bit m_load(input lsu_op_t op);
    return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
  endfunction

  function automatic logic [7:0] m_be(input lsu_op_t op, input logic [63:0] addr);
    logic [15:0] m;
    int off;
    off = int'(addr % 64'd8);
    m = (16'd1 << m_bytes(op)) - 16'd1;
    m = m << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_ext(input lsu_op_t op, input logic [63:0] addr,
                                        input logic [63:0] rdata);
    logic [63:0] r, mask;
    int n, off;
    n = m_bytes(op);
    off = int'(addr % 64'd8);
    r = rdata >> (8 * off);
    if (n == 8) return r;
    mask = (64'd1 << (8 * n)) - 64'd1;
    r = r & mask;
    if ((op inside {LB, LH, LW}) && r[8 * n - 1]) r = r | ~mask;
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("stall", 64'(stall_o), 64'(exp_stall));
    chk("mem_req", 64'(mem_req_o), 64'(exp_req));
    chk("misaligned", 64'(misaligned_o), 64'(exp_mis));
    chk("load_valid", 64'(load_valid_o), 64'(exp_lv));
    chk("load_data", load_data_o, exp_ld);
    if (exp_req) begin
      chk("mem_we", 64'(mem_we_o), 64'(exp_we));
      chk("mem_addr", mem_addr_o, exp_addr);
      chk("mem_be", 64'(mem_be_o), 64'(exp_be));
      chk("mem_wdata", mem_wdata_o, exp_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_idle();
    exp_req = 1'b0; exp_stall = 1'b0; exp_lv = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    snap_req = mem_req_o; snap_we = mem_we_o; snap_stall = stall_o;
    snap_lv = load_valid_o; snap_mis = misaligned_o; snap_wdata = mem_wdata_o;
    snap_ld = load_data_o; snap_be = mem_be_o; snap_addr = mem_addr_o;
    if (stall_o) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rv = 1'b0);
    for (int i = 0; i < n; i++) begin
      lsu_op_i = LSU_NONE; mem_gnt_i = 1'b0; mem_rvalid_i = rv;
      mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
      exp_idle();
      step();
    end
    mem_rvalid_i = 1'b0;
  endtask

  task automatic mis(input lsu_op_t op, input logic [63:0] addr);
    lsu_op_i = op; addr_i = addr; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    exp_idle(); exp_mis = 1'b1;
    step();
    chk("mis_flag", 64'(snap_mis), 64'd1);
    chk("mis_stall", 64'(snap_stall), 64'd0);
    idle(1);
    chk("mis_no_req", 64'(snap_req), 64'd0);
  endtask

  task automatic txn(input lsu_op_t op, input logic [63:0] addr, input logic [63:0] sdata,
                     input int gw, input int rw, input logic [63:0] rdata,
                     input bit rv_with_gnt = 1'b0, input lsu_op_t nop = LSU_NONE,
                     input logic [63:0] naddr = 64'd0);
    stall_cnt = 0;
    lsu_op_i = op; addr_i = addr; store_data_i = sdata;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    exp_idle(); exp_stall = 1'b1;
    step();
    for (int k = 0; k <= gw; k++) begin
      mem_gnt_i = (k == gw);
      mem_rvalid_i = rv_with_gnt && (k == gw);
      mem_rdata_i = ~rdata;
      exp_idle(); exp_stall = 1'b1; exp_req = 1'b1;
      exp_we = m_store(op);
      exp_addr = addr & ~64'h7;
      exp_be = m_be(op, addr);
      exp_wdata = sdata << (8 * int'(addr % 64'd8));
      step();
      if (k == 0) begin
        pin_be = snap_be; pin_wdata = snap_wdata; pin_we = snap_we;
      end
    end
    for (int k = 0; k <= rw; k++) begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = (k == rw);
      mem_rdata_i = (k == rw) ? rdata : ~rdata;
      exp_idle(); exp_stall = 1'b1;
      step();
    end
    mem_rvalid_i = 1'b0;
    lsu_op_i = nop; addr_i = naddr;
    exp_idle();
    if (m_load(op)) begin
      exp_lv = 1'b1;
      exp_ld = m_ext(op, addr, rdata);
    end
    step();
    pin_ld = snap_ld; pin_lv = snap_lv;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; lsu_op_i = LSU_NONE; addr_i = '0; store_data_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    exp_idle(); exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0; exp_ld = '0;
    stall_cnt = 0;

    @(negedge clk);
    chk("rst_be", 64'(mem_be_o), 64'd0);
    chk("rst_addr", mem_addr_o, 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // minimum-latency doubleword load
    txn(LD, 64'h1000, 64'd0, 0, 0, 64'h1122334455667788);
    chk("ld_stall_cycles", 64'(stall_cnt), 64'd3);
    chk("ld_valid", 64'(pin_lv), 64'd1);
    chk("ld_data", pin_ld, 64'h1122334455667788);
    chk("ld_be", 64'(pin_be), 64'hFF);
    chk("ld_we", 64'(pin_we), 64'd0);

    // signed / unsigned byte at lane 3
    txn(LB, 64'h1003, 64'd0, 0, 1, 64'h00000000_80000000);
    chk("lb_be", 64'(pin_be), 64'h08);
    chk("lb_data", pin_ld, 64'hFFFFFFFFFFFFFF80);
    // a misaligned op shows up in DONE but must not be looked at until IDLE
    txn(LBU, 64'h1003, 64'd0, 0, 0, 64'h00000000_80000000, 1'b0, LW, 64'h3002);
    chk("lbu_data", pin_ld, 64'h80);

    mis(LW, 64'h3002);
    mis(LH, 64'h1001);
    mis(LD, 64'h1004);
    mis(SW, 64'h1006);

    // halfword store into the top lanes; next op offered during DONE
    txn(SH, 64'h2006, 64'hABCD, 0, 2, 64'h5555_5555_5555_5555, 1'b0, SD, 64'h5000);
    chk("sh_be", 64'(pin_be), 64'hC0);
    chk("sh_wdata", pin_wdata, 64'hABCD000000000000);
    chk("sh_we", 64'(pin_we), 64'd1);
    chk("sh_no_valid", 64'(pin_lv), 64'd0);
    chk("sh_ld_held", load_data_o, 64'h80);

    txn(SD, 64'h5000, 64'h0123456789ABCDEF, 1, 0, 64'd0);
    chk("sd_be", 64'(pin_be), 64'hFF);

    // grant withheld for 5 cycles, rvalid alongside the grant is dropped
    txn(LW, 64'h2004, 64'd0, 5, 1, 64'h80000001_00000000, 1'b1);
    chk("lw_stall_cycles", 64'(stall_cnt), 64'd9);
    chk("lw_data", pin_ld, 64'hFFFFFFFF80000001);

    txn(LHU, 64'h1006, 64'd0, 0, 0, 64'hFEDC0000_00000000);
    chk("lhu_data", pin_ld, 64'h000000000000FEDC);
    txn(LH, 64'h1006, 64'd0, 2, 0, 64'hFEDC0000_00000000);
    chk("lh_data", pin_ld, 64'hFFFFFFFFFFFFFEDC);
    txn(LWU, 64'h2004, 64'd0, 0, 3, 64'h80000001_00000000);
    chk("lwu_data", pin_ld, 64'h0000000080000001);
    txn(SB, 64'h0007, 64'h1FF, 0, 0, 64'd0);
    chk("sb_be", 64'(pin_be), 64'h80);
    chk("sb_wdata", pin_wdata, 64'hFF00000000000000);

    // rvalid while idle is ignored
    idle(2, 1'b1);
    idle(1);

    // reset pulsed during WAIT, then a stale rvalid
    lsu_op_i = LW; addr_i = 64'h4000; store_data_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    exp_idle(); exp_stall = 1'b1;
    step();
    mem_gnt_i = 1'b1;
    exp_idle(); exp_stall = 1'b1; exp_req = 1'b1; exp_we = 1'b0;
    exp_addr = 64'h4000; exp_be = m_be(LW, 64'h4000); exp_wdata = '0;
    step();
    mem_gnt_i = 1'b0;
    exp_idle(); exp_stall = 1'b1;
    step();
    rst_n = 1'b0; lsu_op_i = LSU_NONE;
    exp_idle(); exp_ld = '0;
    @(negedge clk);
    chk("rst_mid_be", 64'(mem_be_o), 64'd0);
    chk("rst_mid_addr", mem_addr_o, 64'd0);
    chk("rst_mid_wdata", mem_wdata_o, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hCAFE_F00D_CAFE_F00D;
    exp_idle();
    step();
    chk("rst_late_rvalid", 64'(snap_lv), 64'd0);
    idle(2);
    chk("rst_ld_zero", load_data_o, 64'd0);

    // recovery after reset
    txn(LD, 64'h8008, 64'd0, 0, 0, 64'h0F1E2D3C4B5A6978);
    chk("recover_data", pin_ld, 64'h0F1E2D3C4B5A6978);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
